nn_layer_sequencer: RTL and testbench

//  Sequences one hidden layer of ReLU neurons through a full training or inference pass.

---
 rtl/nn_ctrl_pkg.sv | 33 +++
 rtl/nn_layer_sequencer_if.sv | 26 ++
 rtl/nn_layer_sequencer.sv | 125 ++++++++++++
 tb/tb_nn_layer_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared layer-control types: sequencer state encoding and the {fp,bp} phase codes
// that the neuron array and the network controller also decode.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FSETUP  = 3'd1,
        S_FWD     = 3'd2,
        S_WAIT_BP = 3'd3,
        S_BSETUP  = 3'd4,
        S_BWD     = 3'd5,
        S_DONE    = 3'd6
    } seq_state_t;

    localparam logic [1:0] PH_FSETUP = 2'b00;
    localparam logic [1:0] PH_FWD    = 2'b10;
    localparam logic [1:0] PH_BSETUP = 2'b11;
    localparam logic [1:0] PH_BWD    = 2'b01;

    // IDLE, WAIT_BP and DONE share the fwd-setup code so neuron state holds.
    function automatic logic [1:0] phase_of(input seq_state_t s);
        logic [1:0] ph;
        ph = PH_FSETUP;
        case (s)
            S_FWD:    ph = PH_FWD;
            S_BSETUP: ph = PH_BSETUP;
            S_BWD:    ph = PH_BWD;
            default:  ph = PH_FSETUP;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Controller <-> layer sequencer handshake and phase bus.
interface nn_layer_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             train;
    logic             bp_start;
    logic             fp;
    logic             bp;
    logic             ready;
    logic             busy;
    logic             y_valid;
    logic             w_valid;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;

    modport master (
        output start, train, bp_start,
        input  fp, bp, ready, busy, y_valid, w_valid, done, pass_cnt
    );

    modport slave (
        input  start, train, bp_start,
        output fp, bp, ready, busy, y_valid, w_valid, done, pass_cnt
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences one ReLU hidden layer through forward / backward phases: FSM, one shared
// phase down-counter and a completed-training-pass counter; every output is a flop.
module nn_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N            = 6,
    parameter int FP_CYCLES    = N / 2 + 4,
    parameter int BP_CYCLES    = N + 3,
    parameter int SETUP_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nn_layer_sequencer_if.slave  sif
);

    if (FP_CYCLES < 1) begin : g_bad_fp
        $error("FP_CYCLES must be >= 1");
    end
    if (BP_CYCLES < 1) begin : g_bad_bp
        $error("BP_CYCLES must be >= 1");
    end
    if (SETUP_CYCLES < 1) begin : g_bad_setup
        $error("SETUP_CYCLES must be >= 1");
    end

    localparam int MAXC = (FP_CYCLES > BP_CYCLES)
                        ? ((FP_CYCLES > SETUP_CYCLES) ? FP_CYCLES : SETUP_CYCLES)
                        : ((BP_CYCLES > SETUP_CYCLES) ? BP_CYCLES : SETUP_CYCLES);
    localparam int PW   = $clog2(MAXC) + 1;

    localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] FP_LD    = PW'(FP_CYCLES - 1);
    localparam logic [PW-1:0] BP_LD    = PW'(BP_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [PW-1:0]    ph_cnt_q, ph_cnt_d;
    logic             train_q, train_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             y_valid_q, y_valid_d;
    logic             w_valid_q, w_valid_d;
    logic             done_q, done_d;
    logic             ph_zero;

    assign ph_zero = (ph_cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        train_d  = train_q;
        unique case (state_q)
            S_IDLE: if (sif.start) begin
                state_d  = S_FSETUP;
                ph_cnt_d = SETUP_LD;
                train_d  = sif.train;
            end
            S_FSETUP: if (ph_zero) begin
                state_d  = S_FWD;
                ph_cnt_d = FP_LD;
            end else ph_cnt_d = ph_cnt_q - PW'(1);
            S_FWD: if (ph_zero) state_d = train_q ? S_WAIT_BP : S_DONE;
                   else         ph_cnt_d = ph_cnt_q - PW'(1);
            S_WAIT_BP: if (sif.bp_start) begin
                state_d  = S_BSETUP;
                ph_cnt_d = SETUP_LD;
            end
            S_BSETUP: if (ph_zero) begin
                state_d  = S_BWD;
                ph_cnt_d = BP_LD;
            end else ph_cnt_d = ph_cnt_q - PW'(1);
            S_BWD: if (ph_zero) state_d = S_DONE;
                   else         ph_cnt_d = ph_cnt_q - PW'(1);
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they leave flops aligned with it.
        phase_d    = phase_of(state_d);
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        y_valid_d  = (state_q == S_FWD) && (state_d != S_FWD);
        w_valid_d  = (state_q == S_BWD) && (state_d == S_DONE);
        done_d     = (state_d == S_DONE);
        pass_cnt_d = w_valid_d ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_cnt_q   <= '0;
            train_q    <= 1'b0;
            pass_cnt_q <= '0;
            phase_q    <= PH_FSETUP;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            y_valid_q  <= 1'b0;
            w_valid_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            train_q    <= train_d;
            pass_cnt_q <= pass_cnt_d;
            phase_q    <= phase_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            y_valid_q  <= y_valid_d;
            w_valid_q  <= w_valid_d;
            done_q     <= done_d;
        end
    end

    assign sif.fp       = phase_q[1];
    assign sif.bp       = phase_q[0];
    assign sif.ready    = ready_q;
    assign sif.busy     = busy_q;
    assign sif.y_valid  = y_valid_q;
    assign sif.w_valid  = w_valid_q;
    assign sif.done     = done_q;
    assign sif.pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Layer sequencer bench: directed and random start/train/bp_start traffic checked each
// cycle against a timeline model (cycles elapsed since each accepted start / bp_start).
module tb_nn_layer_sequencer;

    localparam int S  = 1;
    localparam int F  = 7;
    localparam int B  = 9;
    localparam int CW = 2;

    logic clk;
    logic rst_n;

    nn_layer_sequencer_if #(.CNT_W(CW)) sif ();

    nn_layer_sequencer #(
        .N(6), .FP_CYCLES(F), .BP_CYCLES(B), .SETUP_CYCLES(S), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Model: 0 idle, 1 forward timeline, 2 waiting for dZ, 3 backward timeline.
    int          m_mode  = 0;
    int          m_el    = 0;
    logic        m_train = 1'b0;
    logic        m_first = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_train = 1'b0; m_first = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic b);
        case (m_mode)
            0: if (s) begin m_mode = 1; m_el = 1; m_train = t; end
            1: if (m_el == S + F + 1) m_mode = 0;
               else begin
                   m_el++;
                   if (m_el == S + F + 1 && m_train) begin m_mode = 2; m_first = 1'b1; end
               end
            2: begin
                m_first = 1'b0;
                if (b) begin m_mode = 3; m_el = 1; end
            end
            default: if (m_el == S + B + 1) m_mode = 0;
               else begin
                   m_el++;
                   if (m_el == S + B + 1) m_cnt = m_cnt + 1'b1;
               end
        endcase
    endtask

    task automatic check_all();
        logic [1:0] ph;
        logic yv, wv, dn, rdy;
        ph = 2'b00; yv = 0; wv = 0; dn = 0; rdy = 0;
        case (m_mode)
            0: rdy = 1;
            1: if (m_el <= S) ph = 2'b00;
               else if (m_el <= S + F) ph = 2'b10;
               else begin yv = 1; dn = 1; end
            2: yv = m_first;
            default: if (m_el <= S) ph = 2'b11;
               else if (m_el <= S + B) ph = 2'b01;
               else begin wv = 1; dn = 1; end
        endcase
        chk("phase",    32'({sif.fp, sif.bp}), 32'(ph));
        chk("ready",    32'(sif.ready),    32'(rdy));
        chk("busy",     32'(sif.busy),     32'(!rdy));
        chk("y_valid",  32'(sif.y_valid),  32'(yv));
        chk("w_valid",  32'(sif.w_valid),  32'(wv));
        chk("done",     32'(sif.done),     32'(dn));
        chk("pass_cnt", 32'(sif.pass_cnt), 32'(m_cnt));
    endtask

    // Inputs change at negedge; model advances on the posedge that samples them.
    task automatic cyc(input logic s, input logic t, input logic b);
        sif.start = s; sif.train = t; sif.bp_start = b;
        @(posedge clk);
        if (rst_n) model_step(s, t, b);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        sif.start = 1'b0; sif.train = 1'b0; sif.bp_start = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Inference pass
        cyc(1'b1, 1'b0, 1'b0);
        idle(12);

        // Training pass, dZ arrives 5 cycles after y_valid
        cyc(1'b1, 1'b1, 1'b0);
        idle(8);
        idle(5);
        cyc(1'b0, 1'b0, 1'b1);
        idle(12);

        // bp_start during FWD ignored, then taken in the y_valid cycle
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        idle(12);

        // start held high: back-to-back passes, start+bp_start together in IDLE
        for (int i = 0; i < 60; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        idle(12);

        // Four training passes wrap the 2-bit pass counter
        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 1'b1, 1'b0);
            idle(8);
            cyc(1'b0, 1'b0, 1'b1);
            idle(11);
        end

        // Async reset mid-FWD
        cyc(1'b1, 1'b1, 1'b0);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("rst_phase", 32'({sif.fp, sif.bp}), 32'd0);
        chk("rst_ready", 32'(sif.ready), 32'd1);
        chk("rst_busy",  32'(sif.busy),  32'd0);
        model_reset();
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(14);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0));
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
